// File: rtl/proj_switch_pkg.sv
// Shared types and default sizing for the project switch controller and the
// input/output muxes that consume its select.
package proj_switch_pkg;

  localparam int NUM_DESIGNS_DEF    = 8;
  localparam int SEL_BITS_DEF       = 3;
  localparam int QUIESCE_CYCLES_DEF = 2;
  localparam int RST_CYCLES_DEF     = 4;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    GATE,
    SWITCH,
    HOLD
  } switch_state_e;

  // A zero-length phase still needs one clocked cycle.
  function automatic int eff_cycles(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/proj_switch_timer.sv
// Phase timer: cleared on load, counts up to limit and holds there (no wrap).
module proj_switch_timer #(
  parameter int W = 2
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (count && (cnt != limit))
      cnt <= cnt + W'(1);
  end

  assign expired = (cnt == limit);

endmodule

// File: rtl/proj_switch_ctrl.sv
// Sequences a switch between multiplexed projects: quiesce, gate, switch, hold.
// Define PROJ_CLK_GATE_EN to gate per-project clocks; otherwise all clocks run.
//
// state   | meaning
// IDLE    | selected project running, requests accepted
// QUIESCE | outgoing project held in reset with clock still running
// GATE    | outgoing project clock stopped
// SWITCH  | sel moves to target, target clock enabled, still in reset
// HOLD    | target held in reset for RST_CYCLES (also the power-on state)
module proj_switch_ctrl
  import proj_switch_pkg::*;
#(
  parameter int NUM_DESIGNS    = NUM_DESIGNS_DEF,
  parameter int SEL_BITS       = SEL_BITS_DEF,
  parameter int QUIESCE_CYCLES = QUIESCE_CYCLES_DEF,
  parameter int RST_CYCLES     = RST_CYCLES_DEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   req_valid,
  input  logic [SEL_BITS-1:0]    req_sel,
  output logic                   req_ready,
  output logic [SEL_BITS-1:0]    sel,
  output logic [NUM_DESIGNS-1:0] proj_clk_en,
  output logic [NUM_DESIGNS-1:0] proj_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int Q_EFF = eff_cycles(QUIESCE_CYCLES);
  localparam int R_EFF = eff_cycles(RST_CYCLES);
  localparam int MAXC  = (Q_EFF > R_EFF) ? Q_EFF : R_EFF;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  switch_state_e       state, next_state;
  logic [SEL_BITS-1:0] tgt, next_sel;
  logic                sel_bad, accept;
  logic                tmr_load, tmr_count, tmr_expired;
  logic [CW-1:0]       tmr_limit;

  function automatic logic [NUM_DESIGNS-1:0] dec(input logic [SEL_BITS-1:0] s);
    dec = {{(NUM_DESIGNS-1){1'b0}}, 1'b1} << s;
  endfunction

  // Out-of-range selects only exist when NUM_DESIGNS is not a power of two.
  generate
    if (NUM_DESIGNS < (2 ** SEL_BITS)) begin : g_range
      assign sel_bad = (32'(req_sel) >= 32'(NUM_DESIGNS));
    end else begin : g_full
      assign sel_bad = 1'b0;
    end
  endgenerate

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready && !sel_bad;
  assign tmr_limit = (state == HOLD) ? CW'(R_EFF - 1) : CW'(Q_EFF - 1);

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_count  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = QUIESCE;
          tmr_load   = 1'b1;
        end
      end
      QUIESCE: begin
        if (tmr_expired) next_state = GATE;
        else             tmr_count  = 1'b1;
      end
      GATE:   next_state = SWITCH;
      SWITCH: begin
        next_state = HOLD;
        tmr_load   = 1'b1;
      end
      HOLD: begin
        if (tmr_expired) next_state = IDLE;
        else             tmr_count  = 1'b1;
      end
      default: next_state = HOLD;
    endcase
    next_sel = (state == GATE) ? tgt : sel;
  end

  proj_switch_timer #(.W(CW)) u_timer (
    .clk_sys (wb_clk_i),
    .rst     (wb_rst_i),
    .load    (tmr_load),
    .count   (tmr_count),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  // Outputs are registered from next-state so resets never glitch.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= HOLD;
      sel        <= '0;
      tgt        <= '0;
      proj_rst_n <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= next_state;
      sel        <= next_sel;
      if (accept) tgt <= req_sel;
      proj_rst_n <= (next_state == IDLE) ? dec(next_sel) : '0;
      done       <= (state == HOLD) && tmr_expired;
      err        <= req_valid && req_ready && sel_bad;
    end
  end

`ifdef PROJ_CLK_GATE_EN
  logic [NUM_DESIGNS-1:0] clk_en_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      clk_en_q <= dec('0);
    else
      clk_en_q <= (next_state == GATE) ? '0 : dec(next_sel);
  end

  assign proj_clk_en = clk_en_q;
`else
  assign proj_clk_en = '1;
`endif

endmodule

// File: tb/tb_proj_switch_ctrl.sv
// Scoreboard bench for proj_switch_ctrl: expected done events queued at
// acceptance, popped by a monitor when the DUT pulses done.
module tb_proj_switch_ctrl;

`ifdef PROJ_CLK_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_sel = '0;
  logic       req_ready, busy, done, err;
  logic [2:0] sel;
  logic [7:0] proj_clk_en, proj_rst_n;

  logic       req_valid6 = 1'b0;
  logic [2:0] req_sel6 = '0;
  logic       req_ready6, busy6, done6, err6;
  logic [2:0] sel6;
  logic [5:0] proj_clk_en6, proj_rst_n6;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    logic [7:0] sel;
    logic [7:0] rst_n;
    logic [7:0] clk_en;
  } exp_t;
  exp_t exp_q[$];

  proj_switch_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .sel(sel), .proj_clk_en(proj_clk_en), .proj_rst_n(proj_rst_n),
    .busy(busy), .done(done), .err(err)
  );

  proj_switch_ctrl #(.NUM_DESIGNS(6), .SEL_BITS(3)) dut6 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .req_valid(req_valid6), .req_sel(req_sel6),
    .req_ready(req_ready6), .sel(sel6), .proj_clk_en(proj_clk_en6), .proj_rst_n(proj_rst_n6),
    .busy(busy6), .done(done6), .err(err6)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [7:0] ungated_or(input logic [7:0] v);
    return GATED ? v : 8'hFF;
  endfunction

  // Monitor: pops the scoreboard whenever done pulses, plus per-cycle invariants.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("done_sel", 32'(sel), 32'(e.sel));
          check("done_rst_n", 32'(proj_rst_n), 32'(e.rst_n));
          check("done_clk_en", 32'(proj_clk_en), 32'(e.clk_en));
          check("done_busy", 32'(busy), 32'd0);
        end
      end
      if (err) check("unexpected_err", 32'd1, 32'd0);
      check("rst_n_only_sel", 32'(proj_rst_n & ~(8'h01 << sel)), 32'd0);
      check("done_err_excl", 32'(done & err), 32'd0);
      if (!GATED) check("clk_en_all_ones", 32'(proj_clk_en), 32'hFF);
    end
  end

  task automatic do_reset();
    int c;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_rst_n", 32'(proj_rst_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_clk_en", 32'(proj_clk_en), 32'(ungated_or(8'h01)));
    exp_q.delete();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    c = cyc;
    exp_q.push_back('{cyc: c + 4, sel: 8'd0, rst_n: 8'h01, clk_en: ungated_or(8'h01)});
    for (int k = 1; k <= 3; k++) begin
      @(negedge wb_clk_i);
      check("rel_rst_n_low", 32'(proj_rst_n), 32'd0);
      check("rel_busy", 32'(busy), 32'd1);
    end
    @(negedge wb_clk_i);
  endtask

  // k counts negedges after the accepting edge; done expected at k == 9.
  task automatic do_switch(input logic [2:0] tgt, input logic [7:0] exp_oh,
                           input logic [2:0] prev_sel, input logic [7:0] prev_oh,
                           input bit poke, input int abort_k);
    int c;
    logic [7:0] ce;
    @(negedge wb_clk_i);
    check("idle_ready", 32'(req_ready), 32'd1);
    c = cyc;
    req_valid = 1'b1;
    req_sel   = tgt;
    exp_q.push_back('{cyc: c + 9, sel: 8'(tgt), rst_n: exp_oh, clk_en: ungated_or(exp_oh)});
    @(negedge wb_clk_i);
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      ce = (k <= 2) ? prev_oh : (k == 3) ? 8'h00 : exp_oh;
      check("seq_rst_n", 32'(proj_rst_n), 32'd0);
      check("seq_ready", 32'(req_ready), 32'd0);
      check("seq_sel", 32'(sel), (k >= 4) ? 32'(tgt) : 32'(prev_sel));
      check("seq_clk_en", 32'(proj_clk_en), 32'(ungated_or(ce)));
      if (k == abort_k) return;
      if (poke && k == 2) begin
        req_valid = 1'b1;
        req_sel   = 3'd3;
      end
      if (k == 3) req_valid = 1'b0;
      @(negedge wb_clk_i);
    end
    @(negedge wb_clk_i);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    do_reset();
    do_switch(3'd5, 8'h20, 3'd0, 8'h01, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      check("busy_req_dropped_sel", 32'(sel), 32'd5);
      check("busy_req_dropped_busy", 32'(busy), 32'd0);
    end
    do_switch(3'd5, 8'h20, 3'd5, 8'h20, 1'b0, 0);
    do_switch(3'd0, 8'h01, 3'd5, 8'h20, 1'b0, 0);
    do_switch(3'd2, 8'h04, 3'd0, 8'h01, 1'b0, 0);

    // Out-of-range requests on a 6-project instance.
    for (int v = 6; v <= 7; v++) begin
      int done_seen;
      @(negedge wb_clk_i);
      req_valid6 = 1'b1;
      req_sel6   = 3'(v);
      @(negedge wb_clk_i);
      req_valid6 = 1'b0;
      check("err6_pulse", 32'(err6), 32'd1);
      check("err6_sel", 32'(sel6), 32'd0);
      check("err6_busy", 32'(busy6), 32'd0);
      check("err6_rst_n", 32'(proj_rst_n6), 32'h01);
      done_seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge wb_clk_i);
        if (k == 0) check("err6_one_cycle", 32'(err6), 32'd0);
        if (done6) done_seen++;
      end
      check("err6_no_done", done_seen, 0);
      check("err6_ready", 32'(req_ready6), 32'd1);
    end

    do_switch(3'd4, 8'h10, 3'd2, 8'h04, 1'b0, 6);
    do_reset();
    do_switch(3'd7, 8'h80, 3'd0, 8'h01, 1'b0, 0);

    repeat (3) @(negedge wb_clk_i);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
